// File: rtl/soc_sram_slave_pkg.sv
// Shared constants and helpers for the SoC SRAM-style responder.
// Provides the confreg address map, the RAM index width and byte-lane merging.
package soc_sram_slave_pkg;

    localparam logic [15:0] CONF_BASE  = 16'hBFAF;
    localparam logic [15:0] OFF_LED    = 16'hF000;
    localparam logic [15:0] OFF_SWITCH = 16'hF004;
    localparam logic [15:0] OFF_NUM    = 16'hF010;
    localparam logic [15:0] OFF_TIMER  = 16'hE000;

    function automatic int ram_idx_w(input int words);
        return $clog2(words);
    endfunction

    // Replace the bytes selected by be, keep the rest of old.
    function automatic logic [31:0] lane_merge(
        input logic [31:0] old,
        input logic [31:0] wd,
        input logic [3:0]  be
    );
        logic [31:0] r;
        r = old;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
        end
        return r;
    endfunction

endpackage

// File: rtl/soc_confreg.sv
// Confreg block: LED, NUM and TIMER registers, switch synchroniser, read mux.
// Ports: clk/resetn, wr_i/be_i/off_i/wdata_i write, switch_i in, rdata_o/led_o/num_o out.
module soc_confreg
    import soc_sram_slave_pkg::*;
#(
    parameter int SW_W = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            wr_i,
    input  logic [3:0]      be_i,
    input  logic [15:0]     off_i,
    input  logic [31:0]     wdata_i,
    input  logic [SW_W-1:0] switch_i,
    output logic [31:0]     rdata_o,
    output logic [SW_W-1:0] led_o,
    output logic [31:0]     num_o
);

    logic [SW_W-1:0] led_q, led_d;
    logic [SW_W-1:0] sw_s1_q, sw_s2_q;
    logic [31:0]     num_q, num_d;
    logic [31:0]     timer_q, timer_d;
    logic            hit_led, hit_sw, hit_num, hit_tmr;

    assign hit_led = (off_i == OFF_LED);
    assign hit_sw  = (off_i == OFF_SWITCH);
    assign hit_num = (off_i == OFF_NUM);
    assign hit_tmr = (off_i == OFF_TIMER);

    always_comb begin
        led_d   = led_q;
        num_d   = num_q;
        timer_d = timer_q + 32'd1;
        if (wr_i) begin
            unique case (1'b1)
                hit_led: begin
                    for (int i = 0; i < SW_W; i++) begin
                        if (be_i[i/8]) led_d[i] = wdata_i[i];
                    end
                end
                hit_num: num_d   = lane_merge(num_q, wdata_i, be_i);
                // A write replaces this cycle's increment.
                hit_tmr: timer_d = lane_merge(timer_q, wdata_i, be_i);
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_o = '0;
        unique case (1'b1)
            hit_led: rdata_o[SW_W-1:0] = led_q;
            hit_sw:  rdata_o[SW_W-1:0] = sw_s2_q;
            hit_num: rdata_o = num_q;
            hit_tmr: rdata_o = timer_q;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            led_q   <= '0;
            num_q   <= '0;
            timer_q <= '0;
            sw_s1_q <= '0;
            sw_s2_q <= '0;
        end else begin
            led_q   <= led_d;
            num_q   <= num_d;
            timer_q <= timer_d;
            sw_s1_q <= switch_i;
            sw_s2_q <= sw_s1_q;
        end
    end

    assign led_o = led_q;
    assign num_o = num_q;

endmodule

// File: rtl/soc_sram_slave.sv
// SRAM-style responder: 64-bit fetch port, 32-bit byte-enabled data port, confreg.
// Ports: inst_sram_* (read-only fetch), data_sram_*, switch_in, led_out, num_out.
module soc_sram_slave
    import soc_sram_slave_pkg::*;
#(
    parameter int MEM_WORDS = 16384,
    parameter int SW_W      = 16
) (
    input  logic            clk,
    input  logic            resetn,
    input  logic            inst_sram_en,
    input  logic [7:0]      inst_sram_wen,
    input  logic [31:0]     inst_sram_addr,
    input  logic [63:0]     inst_sram_wdata,
    output logic [63:0]     inst_sram_rdata,
    input  logic            data_sram_en,
    input  logic [3:0]      data_sram_wen,
    input  logic [31:0]     data_sram_addr,
    input  logic [31:0]     data_sram_wdata,
    output logic [31:0]     data_sram_rdata,
    input  logic [SW_W-1:0] switch_in,
    output logic [SW_W-1:0] led_out,
    output logic [31:0]     num_out
);

    localparam int IDX_W = ram_idx_w(MEM_WORDS);

    logic [31:0]      mem [MEM_WORDS];
    logic             conf_sel, ram_wr, conf_wr;
    logic [IDX_W-1:0] d_idx, i_idx_lo, i_idx_hi;
    logic [31:0]      conf_rdata;
    logic [63:0]      inst_rdata_q, inst_rdata_d;
    logic [31:0]      data_rdata_q, data_rdata_d;
    logic             unused_in;

    assign unused_in = ^{inst_sram_wen, inst_sram_wdata,
                         inst_sram_addr, data_sram_addr[1:0]};

    assign conf_sel = (data_sram_addr[31:16] == CONF_BASE);
    assign ram_wr   = data_sram_en && !conf_sel && (data_sram_wen != 4'b0);
    assign conf_wr  = data_sram_en && conf_sel && (data_sram_wen != 4'b0);

    assign d_idx    = data_sram_addr[IDX_W+1:2];
    assign i_idx_lo = {inst_sram_addr[IDX_W+1:3], 1'b0};
    assign i_idx_hi = {inst_sram_addr[IDX_W+1:3], 1'b1};

    // Uninitialised storage; reads sample pre-edge contents (read-before-write).
    always_ff @(posedge clk) begin
        if (ram_wr) begin
            for (int i = 0; i < 4; i++) begin
                if (data_sram_wen[i])
                    mem[d_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
            end
        end
    end

    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        if (inst_sram_en)
            inst_rdata_d = {mem[i_idx_hi], mem[i_idx_lo]};
        if (data_sram_en)
            data_rdata_d = conf_sel ? conf_rdata : mem[d_idx];
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
        end else begin
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
        end
    end

    assign inst_sram_rdata = inst_rdata_q;
    assign data_sram_rdata = data_rdata_q;

    soc_confreg #(
        .SW_W(SW_W)
    ) u_confreg (
        .clk      (clk),
        .resetn   (resetn),
        .wr_i     (conf_wr),
        .be_i     (data_sram_wen),
        .off_i    (data_sram_addr[15:0]),
        .wdata_i  (data_sram_wdata),
        .switch_i (switch_in),
        .rdata_o  (conf_rdata),
        .led_o    (led_out),
        .num_o    (num_out)
    );

endmodule

// File: tb/tb_soc_sram_slave.sv
// Directed bench for soc_sram_slave: RAM, fetch pairing, collisions, confreg.
// Inputs change on the falling edge; outputs are checked on the next falling edge.
module tb_soc_sram_slave;

    logic        clk;
    logic        resetn;
    logic        inst_sram_en;
    logic [7:0]  inst_sram_wen;
    logic [31:0] inst_sram_addr;
    logic [63:0] inst_sram_wdata;
    logic [63:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic [15:0] switch_in;
    logic [15:0] led_out;
    logic [31:0] num_out;

    int checks;
    int errors;

    soc_sram_slave #(
        .MEM_WORDS(16384),
        .SW_W(16)
    ) dut (
        .clk             (clk),
        .resetn          (resetn),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_wen   (inst_sram_wen),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_wdata (inst_sram_wdata),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .switch_in       (switch_in),
        .led_out         (led_out),
        .num_out         (num_out)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic dwrite(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] be);
        data_sram_en    = 1'b1;
        data_sram_wen   = be;
        data_sram_addr  = a;
        data_sram_wdata = d;
        @(negedge clk);
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
    endtask

    task automatic dread(input logic [31:0] a, output logic [31:0] r);
        data_sram_en   = 1'b1;
        data_sram_wen  = 4'h0;
        data_sram_addr = a;
        @(negedge clk);
        data_sram_en   = 1'b0;
        r = data_sram_rdata;
    endtask

    task automatic fetch(input logic [31:0] a, output logic [63:0] r);
        inst_sram_en   = 1'b1;
        inst_sram_addr = a;
        @(negedge clk);
        inst_sram_en   = 1'b0;
        r = inst_sram_rdata;
    endtask

    logic [31:0] rd;
    logic [63:0] fr;

    initial begin
        checks          = 0;
        errors          = 0;
        resetn          = 1'b0;
        inst_sram_en    = 1'b0;
        inst_sram_wen   = 8'hFF;
        inst_sram_addr  = '0;
        inst_sram_wdata = 64'hFFFF_FFFF_FFFF_FFFF;
        data_sram_en    = 1'b0;
        data_sram_wen   = 4'h0;
        data_sram_addr  = '0;
        data_sram_wdata = '0;
        switch_in       = 16'h0000;

        // Requests during reset must not produce data.
        data_sram_en   = 1'b1;
        data_sram_addr = 32'hBFAF_E000;
        inst_sram_en   = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_inst_rdata", inst_sram_rdata, 64'h0);
        chk("rst_data_rdata", {32'h0, data_sram_rdata}, 64'h0);
        chk("rst_led", {48'h0, led_out}, 64'h0);
        chk("rst_num", {32'h0, num_out}, 64'h0);
        data_sram_en = 1'b0;
        inst_sram_en = 1'b0;

        resetn = 1'b1;
        dread(32'hBFAF_E000, rd);
        chk("timer_first", {32'h0, rd}, 64'h0);
        dread(32'hBFAF_E000, rd);
        chk("timer_second", {32'h0, rd}, 64'h1);

        // Byte-lane write into RAM.
        dwrite(32'h0000_0100, 32'h1122_3344, 4'hF);
        dwrite(32'h0000_0100, 32'h0000_AA00, 4'b0010);
        dread(32'h0000_0100, rd);
        chk("byte_write", {32'h0, rd}, {32'h0, 32'h1122_AA44});
        @(negedge clk);
        chk("rdata_hold", {32'h0, data_sram_rdata}, {32'h0, 32'h1122_AA44});

        // Fetch pairs two words; addr[2] ignored.
        dwrite(32'h0000_0100, 32'hDEAD_BEEF, 4'hF);
        dwrite(32'h0000_0104, 32'hCAFE_F00D, 4'hF);
        fetch(32'h0000_0104, fr);
        chk("fetch_pair_104", fr, 64'hCAFE_F00D_DEAD_BEEF);
        fetch(32'h0000_0100, fr);
        chk("fetch_pair_100", fr, 64'hCAFE_F00D_DEAD_BEEF);

        // Collision: same-cycle fetch sees old data.
        inst_sram_en    = 1'b1;
        inst_sram_addr  = 32'h0000_0100;
        data_sram_en    = 1'b1;
        data_sram_wen   = 4'hF;
        data_sram_addr  = 32'h0000_0100;
        data_sram_wdata = 32'h0000_0055;
        @(negedge clk);
        inst_sram_en  = 1'b0;
        data_sram_en  = 1'b0;
        data_sram_wen = 4'h0;
        chk("collide_old", inst_sram_rdata, 64'hCAFE_F00D_DEAD_BEEF);
        fetch(32'h0000_0100, fr);
        chk("collide_new", fr, 64'hCAFE_F00D_0000_0055);

        // Read immediately after write.
        dwrite(32'h0000_0200, 32'hA5A5_5A5A, 4'hF);
        dread(32'h0000_0200, rd);
        chk("raw_next_cycle", {32'h0, rd}, {32'h0, 32'hA5A5_5A5A});

        // LED register with lanes.
        dwrite(32'hBFAF_F000, 32'h0000_ABCD, 4'hF);
        chk("led_out", {48'h0, led_out}, 64'hABCD);
        dwrite(32'hBFAF_F000, 32'hFFFF_12FF, 4'b0010);
        chk("led_lane", {48'h0, led_out}, 64'h12CD);
        dread(32'hBFAF_F000, rd);
        chk("led_read", {32'h0, rd}, 64'h12CD);

        // NUM register.
        dwrite(32'hBFAF_F010, 32'h1234_5678, 4'hF);
        chk("num_out", {32'h0, num_out}, 64'h1234_5678);
        dwrite(32'hBFAF_F010, 32'h0000_0099, 4'b0001);
        dread(32'hBFAF_F010, rd);
        chk("num_lane_read", {32'h0, rd}, 64'h1234_5699);

        // Switch through synchroniser; writes ignored.
        switch_in = 16'h00F0;
        repeat (4) @(negedge clk);
        dread(32'hBFAF_F004, rd);
        chk("switch_read", {32'h0, rd}, 64'hF0);
        dwrite(32'hBFAF_F004, 32'hFFFF_FFFF, 4'hF);
        dread(32'hBFAF_F004, rd);
        chk("switch_ro", {32'h0, rd}, 64'hF0);

        // Unmapped confreg offset: reads 0 and does not touch RAM.
        dwrite(32'h0000_F008, 32'h0BAD_CAFE, 4'hF);
        dwrite(32'hBFAF_F008, 32'hDEAD_BEEF, 4'hF);
        dread(32'hBFAF_F008, rd);
        chk("conf_unmapped", {32'h0, rd}, 64'h0);
        dread(32'h0000_F008, rd);
        chk("conf_no_ram", {32'h0, rd}, {32'h0, 32'h0BAD_CAFE});

        // Timer write, then wrap.
        dwrite(32'hBFAF_E000, 32'hFFFF_FFFE, 4'hF);
        @(negedge clk);
        dread(32'hBFAF_E000, rd);
        chk("timer_ffff", {32'h0, rd}, {32'h0, 32'hFFFF_FFFF});
        dread(32'hBFAF_E000, rd);
        chk("timer_wrap", {32'h0, rd}, 64'h0);

        // RAM index wrap.
        dwrite(32'h0001_0000, 32'h600D_F00D, 4'hF);
        dread(32'h0000_0000, rd);
        chk("ram_wrap", {32'h0, rd}, {32'h0, 32'h600D_F00D});

        // Reset mid-access discards the response.
        data_sram_en   = 1'b1;
        data_sram_addr = 32'h0000_0200;
        #2 resetn = 1'b0;
        @(negedge clk);
        chk("midrst_data", {32'h0, data_sram_rdata}, 64'h0);
        chk("midrst_led", {48'h0, led_out}, 64'h0);
        chk("midrst_num", {32'h0, num_out}, 64'h0);
        data_sram_en = 1'b0;
        resetn = 1'b1;
        dread(32'h0000_0200, rd);
        chk("postrst_read", {32'h0, rd}, {32'h0, 32'hA5A5_5A5A});

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/soc_sram_slave.md
# soc_sram_slave

Responder end of the CPU's SRAM-style instruction and data ports: services 64-bit instruction fetches and 32-bit byte-enabled data accesses with a fixed one-cycle read latency. It holds the on-chip RAM plus a small confreg region (LED, switch, number display, free-running timer). It sits in the SoC top directly opposite the CPU core's inst/data SRAM master ports.

## Interface
- MEM_WORDS, 16384, RAM depth in 32-bit words; power of two, ≥ 4
- SW_W, 16, width of switch input and LED output
- clk  in  1  single clock; all state updates on rising edge
- resetn  in  1  asynchronous, active-low reset
- inst_sram_en  in  1  fetch request this cycle
- inst_sram_wen  in  8  ignored; fetch port is read-only
- inst_sram_addr  in  32  fetch byte address
- inst_sram_wdata  in  64  ignored
- inst_sram_rdata  out  64  fetch data, valid the cycle after request
- data_sram_en  in  1  data access this cycle
- data_sram_wen  in  4  byte-lane write enables; 0 = read
- data_sram_addr  in  32  data byte address
- data_sram_wdata  in  32  write data, lane i = bits 8i+7:8i
- data_sram_rdata  out  32  read data, valid the cycle after request
- switch_in  in  SW_W  board switches, asynchronous to clk
- led_out  out  SW_W  LED register
- num_out  out  32  number-display register

## Operation
- Address decode (data port only): addr[31:16]==16'hBFAF → confreg; else RAM. Fetch port always reads RAM.
- RAM index = addr[log2(MEM_WORDS)+1:2]; higher bits ignored (wrap-around). addr[1:0] ignored.
- Fetch: addr[2] ignored; rdata = {RAM[idx|1], RAM[idx&~1]} (low word = lower address).
- Data write: each lane with wen[i]=1 updated; others preserved. Writes with en=0 ignored.
- Data read (wen==0): returns full word; CPU extracts bytes.
- Confreg map (offset addr[15:0]): 16'hF000 LED (RW, low SW_W bits, upper read 0); 16'hF004 SWITCH (RO, 2-flop synchronised switch_in, zero-extended; writes ignored); 16'hF010 NUM (RW, 32 bits); 16'hE000 TIMER (RW, 32-bit free-running +1 per clk). Other confreg offsets: read 0, writes dropped.
- Confreg writes honour byte lanes.
- TIMER: increments every cycle, wraps 0xFFFFFFFF→0. Same-cycle write: written value wins, increment resumes next cycle from written value (no +1 that cycle).
- Simultaneous fetch and data write to same RAM word: fetch returns old value (read-before-write).
- Data read-after-write to same word in next cycle returns new value.

## Timing
- Read latency exactly 1 cycle on both ports; no stall/wait, no back-pressure.
- rdata registered; when en=0, rdata holds previous value.
- Reset (asynchronous, active-low): inst_sram_rdata=0, data_sram_rdata=0, led_out=0, num_out=0, TIMER=0, switch sync flops=0. RAM contents not reset.
- Reset asserted mid-access: pending response discarded; first post-reset rdata reflects a request made after resetn rises.
- SWITCH read reflects switch_in with 2–3 cycle sync latency.
- Both ports independently accepted every cycle.

## Structure
- Shared package: confreg base 16'hBFAF, offsets (LED, SWITCH, NUM, TIMER), RAM word-index width function.
- One sub-module natural: soc_confreg (LED/NUM/TIMER registers, switch sync, read mux); RAM array and port logic stay in top.

## Test plan
- Reset: hold resetn=0 → both rdata=0, led_out=0, num_out=0, TIMER reads 0 first cycle after release (+1 per following cycle).
- Byte write: write 0x11223344 wen=4'hF at 0x100, then wen=4'b0010 data 0x0000AA00 → read 0x100 returns 0x1122AA44 one cycle later.
- Fetch pair: RAM[0x40]=0xDEADBEEF, RAM[0x41]=0xCAFEF00D; fetch addr 0x104 → inst_sram_rdata=0xCAFEF00D_DEADBEEF.
- Collision: fetch and data-write 0x55 to same word same cycle → fetch returns old value; next fetch returns new.
- Confreg: write 0x0000ABCD to 0xBFAFF000 → led_out=0xABCD; switch_in=0x00F0 held 4 cycles, read 0xBFAFF004 → 0x000000F0; write TIMER 0xFFFFFFFE → reads 0xFFFFFFFF, then 0x00000000 wrap.
- Wrap: MEM_WORDS=16384, write at 0x0001_0000 → readable at 0x0000_0000.
